// File: rtl/cp0_unit.sv
// cp0_unit -- System Control Coprocessor (CP0) for the 5-stage MIPS pipeline.
//
// Sits beside the Memory stage. It watches the M-stage instruction (victim
// PC, branch-delay flag, pending exception code) and the external interrupt
// lines, and raises `req` when the pipeline must flush and vector to the
// exception handler. It also implements the SR, Cause, EPC and PRId registers
// for mfc0 / mtc0 / eret.
//
// Ports:
//   clk          clock
//   reset        synchronous, active-high reset
//   en           mtc0 write strobe (M-stage instruction)
//   cp0_addr     CP0 register number: 12 SR, 13 Cause, 14 EPC, 15 PRId
//   cp0_wdata    mtc0 write data
//   cp0_rdata    mfc0 read data, combinational from cp0_addr
//   vpc          victim PC of the M-stage instruction
//   bd_in        M-stage instruction sits in a branch delay slot
//   exc_code_in  pending exception code, 0 = none
//   hw_int       hardware interrupt lines, level-sensitive
//   exl_clr      eret in M stage, clears EXL
//   epc_out      current EPC value (eret target)
//   req          exception/interrupt taken this cycle, combinational
//
// There is no FSM and no valid/ready handshake in this block: `req` is a
// level that the pipeline consumes in the same cycle, and EXL rising at the
// following edge is what ends it.

module cp0_unit #(
  parameter logic [31:0] PRID = 32'h2021_0007
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [4:0]  cp0_addr,
  input  logic [31:0] cp0_wdata,
  output logic [31:0] cp0_rdata,
  input  logic [31:0] vpc,
  input  logic        bd_in,
  input  logic [4:0]  exc_code_in,
  input  logic [5:0]  hw_int,
  input  logic        exl_clr,
  output logic [31:0] epc_out,
  output logic        req
);

  localparam logic [4:0] ADDR_SR    = 5'd12;
  localparam logic [4:0] ADDR_CAUSE = 5'd13;
  localparam logic [4:0] ADDR_EPC   = 5'd14;
  localparam logic [4:0] ADDR_PRID  = 5'd15;

  // SR fields
  logic [5:0]  im_q, im_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  // Cause fields
  logic        bd_q, bd_d;
  logic [5:0]  ip_q, ip_d;
  logic [4:0]  exc_code_q, exc_code_d;
  // EPC, low two bits are always zero
  logic [31:0] epc_q, epc_d;

  logic        int_req;
  logic        exc_req;
  logic [31:0] victim_pc;

  // Request logic. EXL masks both sources so a handler is never re-entered.
  assign int_req = (|(hw_int & im_q)) & ie_q & ~exl_q;
  assign exc_req = (exc_code_in != 5'd0) & ~exl_q;
  assign req     = int_req | exc_req;

  // A delay-slot instruction restarts at its branch, one word earlier.
  // Subtraction is 32-bit modulo, so vpc = 0 wraps to 0xFFFF_FFFC.
  assign victim_pc = bd_in ? (vpc - 32'd4) : vpc;

  always_comb begin
    im_d       = im_q;
    exl_d      = exl_q;
    ie_d       = ie_q;
    bd_d       = bd_q;
    exc_code_d = exc_code_q;
    epc_d      = epc_q;
    // IP mirrors the interrupt lines every cycle, independent of events.
    ip_d       = hw_int;

    if (req) begin
      // Taking the exception overrides any concurrent mtc0 / eret.
      exl_d      = 1'b1;
      bd_d       = bd_in;
      exc_code_d = int_req ? 5'd0 : exc_code_in;
      epc_d      = victim_pc & 32'hFFFF_FFFC;
    end else begin
      if (en) begin
        case (cp0_addr)
          ADDR_SR: begin
            im_d  = cp0_wdata[15:10];
            exl_d = cp0_wdata[1];
            ie_d  = cp0_wdata[0];
          end
          ADDR_EPC: epc_d = cp0_wdata & 32'hFFFF_FFFC;
          default: ;  // Cause and PRId are not software-writable
        endcase
      end
      // Placed after the mtc0 so that an SR write in the same cycle as eret
      // lands first and EXL still ends up cleared.
      if (exl_clr) exl_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      im_q       <= 6'd0;
      exl_q      <= 1'b0;
      ie_q       <= 1'b0;
      bd_q       <= 1'b0;
      ip_q       <= 6'd0;
      exc_code_q <= 5'd0;
      epc_q      <= 32'd0;
    end else begin
      im_q       <= im_d;
      exl_q      <= exl_d;
      ie_q       <= ie_d;
      bd_q       <= bd_d;
      ip_q       <= ip_d;
      exc_code_q <= exc_code_d;
      epc_q      <= epc_d;
    end
  end

  // mfc0 sees the pre-edge register values; no write-to-read bypass.
  always_comb begin
    cp0_rdata = 32'd0;
    case (cp0_addr)
      ADDR_SR:    cp0_rdata = {16'd0, im_q, 8'd0, exl_q, ie_q};
      ADDR_CAUSE: cp0_rdata = {bd_q, 15'd0, ip_q, 3'd0, exc_code_q, 2'b00};
      ADDR_EPC:   cp0_rdata = epc_q;
      ADDR_PRID:  cp0_rdata = PRID;
      default:    cp0_rdata = 32'd0;
    endcase
  end

  assign epc_out = epc_q;

endmodule
